// File: rtl/dd_sync_pkg.sv
// Shared types and helpers for the multi-channel synchronizer/debouncer.
package dd_sync_pkg;

  // Edge-pulse pair emitted by each channel
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Stability counter width: max(1, clog2(n))
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dd_sync_filt_ch.sv
// One channel: synchronizer flop chain, stability filter and registered edge pulses.
module dd_sync_filt_ch
  import dd_sync_pkg::*;
#(
  parameter int unsigned STAGES   = 2,
  parameter int unsigned FILT_CNT = 8,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold_i,
  input  logic  data_i,
  output logic  data_sync_o,
  output edge_t edge_o
);

  localparam int unsigned     CNT_W   = cnt_width(FILT_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT - 1);

  logic [STAGES-1:0] pipe;
  logic [CNT_W-1:0]  cnt;
  logic              s;

  assign s = pipe[STAGES-1];

  // Chain always shifts; the filter and pulses freeze while hold_i is high
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe        <= {STAGES{RST_VAL}};
      data_sync_o <= RST_VAL;
      cnt         <= '0;
      edge_o      <= '0;
    end else begin
      pipe   <= {pipe[STAGES-2:0], data_i};
      edge_o <= '0;
      if (!hold_i) begin
        if (s == data_sync_o) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          data_sync_o <= s;
          cnt         <= '0;
          edge_o.rise <= s;
          edge_o.fall <= ~s;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dd_sync_debounce.sv
// Multi-channel synchronizer with per-channel glitch filter and rise/fall pulses.
module dd_sync_debounce
  import dd_sync_pkg::*;
#(
  parameter int unsigned        NUM_CH   = 4,
  parameter int unsigned        STAGES   = 2,
  parameter int unsigned        FILT_CNT = 8,
  parameter logic [NUM_CH-1:0]  RST_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic [NUM_CH-1:0] data_i,
  output logic [NUM_CH-1:0] data_sync_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic              chg_o
);

  edge_t edges [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dd_sync_filt_ch #(
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .hold_i      (hold_i),
      .data_i      (data_i[i]),
      .data_sync_o (data_sync_o[i]),
      .edge_o      (edges[i])
    );

    assign rise_o[i] = edges[i].rise;
    assign fall_o[i] = edges[i].fall;
  end

  // Pulses are registered, so this reduction is glitch-free
  assign chg_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_dd_sync_debounce.sv
// Directed bench for dd_sync_debounce (NUM_CH=4, STAGES=2, FILT_CNT=8, RST_VAL=4'b0101).
module tb_dd_sync_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold_i;
  logic [3:0] data_i;
  logic [3:0] data_sync_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       chg_o;

  int tests_run    = 0;
  int tests_failed = 0;

  dd_sync_debounce #(
    .NUM_CH   (4),
    .STAGES   (2),
    .FILT_CNT (8),
    .RST_VAL  (4'b0101)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold_i),
    .data_i      (data_i),
    .data_sync_o (data_sync_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .chg_o       (chg_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rst held for 3 edges, then data 1010 accepted 10 edges after release
  task automatic test_reset();
    logic [12:0] got, exp;
    rst    = 1'b1;
    hold_i = 1'b0;
    data_i = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      got = {data_sync_o, rise_o, fall_o, chg_o};
      exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset k=%0d got %b exp %b", k, got, exp);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b1010, 4'b1010, 4'b0101, 1'b1};
      else              exp = {4'b1010, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL post_reset k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // ch0 0->1: change after 9 edges past capture, single rise pulse
  task automatic test_latency();
    logic [12:0] got, exp;
    data_i = 4'b1011;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b1010, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b1011, 4'b0001, 4'b0000, 1'b1};
      else              exp = {4'b1011, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL latency k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // ch1: drive low, then a 7-cycle high (rejected) and an 8-cycle high (accepted)
  task automatic test_glitch();
    logic [12:0] got, exp;
    data_i = 4'b1001;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b1011, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b1001, 4'b0000, 4'b0010, 1'b1};
      else              exp = {4'b1001, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch_setup k=%0d got %b exp %b", k, got, exp);
      end
    end
    data_i = 4'b1011;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 7) data_i = 4'b1001;
      exp = {4'b1001, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch_7 k=%0d got %b exp %b", k, got, exp);
      end
    end
    data_i = 4'b1011;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 8) data_i = 4'b1001;
      exp[12:9] = (k >= 10 && k < 18) ? 4'b1011 : 4'b1001;
      exp[8:5]  = (k == 10) ? 4'b0010 : 4'b0000;
      exp[4:1]  = (k == 18) ? 4'b0010 : 4'b0000;
      exp[0]    = (k == 10 || k == 18);
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch_8 k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // ch1 step; hold after 4 counted edges for 20 edges; 4 more edges after release
  task automatic test_hold();
    logic [12:0] got, exp;
    data_i = 4'b1011;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 6)  hold_i = 1'b1;
      if (k == 26) hold_i = 1'b0;
      exp[12:9] = (k >= 30) ? 4'b1011 : 4'b1001;
      exp[8:5]  = (k == 30) ? 4'b0010 : 4'b0000;
      exp[4:1]  = 4'b0000;
      exp[0]    = (k == 30);
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL hold k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // All channels step together, then ch2 bounces with 3-cycle lows
  task automatic test_simultaneous();
    logic [12:0] got, exp;
    data_i = 4'b0000;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b1011, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b0000, 4'b0000, 4'b1011, 1'b1};
      else              exp = {4'b0000, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL all_fall k=%0d got %b exp %b", k, got, exp);
      end
    end
    data_i = 4'b1111;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b0000, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b1111, 4'b1111, 4'b0000, 1'b1};
      else              exp = {4'b1111, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL all_rise k=%0d got %b exp %b", k, got, exp);
      end
    end
    for (int k = 1; k <= 24; k++) begin
      data_i = (k <= 12 && ((k - 1) / 3) % 2 == 0) ? 4'b1011 : 4'b1111;
      tick();
      exp = {4'b1111, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL bounce k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  // Settle at RST_VAL, start a ch1 rise, reset at cnt=5, expect full delay after release
  task automatic test_reset_mid();
    logic [12:0] got, exp;
    data_i = 4'b0101;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k < 10)       exp = {4'b1111, 4'b0000, 4'b0000, 1'b0};
      else if (k == 10) exp = {4'b0101, 4'b0000, 4'b1010, 1'b1};
      else              exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL mid_setup k=%0d got %b exp %b", k, got, exp);
      end
    end
    data_i = 4'b0111;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 7) rst = 1'b1;
      if (k == 8) rst = 1'b0;
      exp[12:9] = (k >= 18) ? 4'b0111 : 4'b0101;
      exp[8:5]  = (k == 18) ? 4'b0010 : 4'b0000;
      exp[4:1]  = 4'b0000;
      exp[0]    = (k == 18);
      got = {data_sync_o, rise_o, fall_o, chg_o};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL reset_mid k=%0d got %b exp %b", k, got, exp);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    hold_i = 1'b0;
    data_i = 4'b1010;
    test_reset();
    test_latency();
    test_glitch();
    test_hold();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
